// File: rtl/serpent_job_scheduler_if.sv
// ----------------------------------------------------------------------------
// serpent_job_scheduler_if
// Bundles the signals between the job scheduler, its two requesters and the
// shared Serpent cipher core.
//   req_valid/req_ready/req_data0/req_data1 : block requests from requesters
//   core_go/core_data_in/core_abort          : scheduler -> cipher core
//   core_done/core_data_out                  : cipher core -> scheduler
//   resp_valid/resp_ready/resp_data/resp_err : results back to requesters
// Modports: slave = scheduler, master = environment (requesters + core).
// ----------------------------------------------------------------------------
interface serpent_job_scheduler_if #(
    parameter int DATA_W = 128
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic              core_go;
    logic [DATA_W-1:0] core_data_in;
    logic              core_done;
    logic [DATA_W-1:0] core_data_out;
    logic              core_abort;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_data0, req_data1, core_done, core_data_out, resp_ready,
        output req_ready, core_go, core_data_in, core_abort, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_data0, req_data1, core_done, core_data_out, resp_ready,
        input  req_ready, core_go, core_data_in, core_abort, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/serpent_job_scheduler.sv
// ----------------------------------------------------------------------------
// serpent_job_scheduler
// Shares one Serpent cipher core between two requesters. Requests are granted
// round-robin, the core is started with a one-cycle go pulse, and the result
// is held until the owning requester takes it. A watchdog aborts jobs that
// stay in WAIT for TIMEOUT_CYCLES and returns them with resp_err=1, data 0.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : request / core / response signals (slave modport)
//   busy  : 1 in every state except IDLE
// ----------------------------------------------------------------------------
module serpent_job_scheduler #(
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 160
) (
    input  logic                    clk,
    input  logic                    n_rst,
    serpent_job_scheduler_if.slave  bus,
    output logic                    busy
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ABORT,
        ST_RESP
    } state_t;

    state_t              state_reg, state_next;
    logic                owner_reg;
    logic                last_grant_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                err_reg;

    logic                grant_idx;
    logic                accept;
    logic                timeout_hit;
    logic                resp_take;

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that did not win last time is chosen.
    always_comb begin
        grant_idx = (bus.req_valid == 2'b11) ? ~last_grant_reg : bus.req_valid[1];
        accept    = (state_reg == ST_IDLE) && (|bus.req_valid);
    end

    assign timeout_hit = (timer_reg == TIMER_LAST);
    assign resp_take   = bus.resp_ready[owner_reg];

    // req_ready is the only output not decoded purely from the registered state
    assign bus.req_ready = accept ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                // done takes priority over a coincident timeout
                if (bus.core_done)    state_next = ST_RESP;
                else if (timeout_hit) state_next = ST_ABORT;
            end
            ST_ABORT: state_next = ST_RESP;
            ST_RESP:  if (resp_take) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Job datapath: ownership, watchdog timer, held block and error flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            timer_reg      <= '0;
            data_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        data_reg  <= grant_idx ? bus.req_data1 : bus.req_data0;
                        owner_reg <= grant_idx;
                    end
                end
                ST_ISSUE: timer_reg <= '0;
                ST_WAIT: begin
                    if (bus.core_done) begin
                        data_reg <= bus.core_data_out;
                        err_reg  <= 1'b0;
                    end else if (!timeout_hit) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_ABORT: begin
                    data_reg <= '0;
                    err_reg  <= 1'b1;
                end
                ST_RESP: begin
                    if (resp_take) last_grant_reg <= owner_reg;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        bus.core_go      = 1'b0;
        bus.core_abort   = 1'b0;
        bus.core_data_in = '0;
        bus.resp_valid   = 2'b00;
        bus.resp_data    = '0;
        bus.resp_err     = 1'b0;
        busy             = (state_reg != ST_IDLE);
        case (state_reg)
            ST_ISSUE: begin
                bus.core_go      = 1'b1;
                bus.core_data_in = data_reg;
            end
            ST_WAIT:  bus.core_data_in = data_reg;
            ST_ABORT: begin
                bus.core_abort   = 1'b1;
                bus.core_data_in = data_reg;
            end
            ST_RESP: begin
                bus.resp_valid = owner_reg ? 2'b10 : 2'b01;
                bus.resp_data  = data_reg;
                bus.resp_err   = err_reg;
            end
            default: ;
        endcase
    end
endmodule
